jtag_tap: RTL and testbench

Parameterised IEEE 1149.1 TAP controller. It replaces the fixed-width IDCODE-only TAP and adds a real instruction register, BYPASS, and a user data register with capture and update hooks into the core. It sits between the chip JTAG pins and core debug logic. Everything runs in the tck domain on a single edge (posedge); the core synchronises user_update itself.

---
 rtl/jtag_tap.sv | 179 +++++++++++++++++
 tb/tb_jtag_tap.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP: 16-state controller, IR, IDCODE/BYPASS/USER data registers; tck domain, posedge only.
// tdo is combinational from the shift registers; enable=0 freezes all state (no backpressure otherwise).
module jtag_tap #(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h000FAF01,
    parameter int                  USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0] INST_IDCODE   = 4'b1110,
    parameter logic [IR_WIDTH-1:0] INST_BYPASS   = 4'b1111,
    parameter logic [IR_WIDTH-1:0] INST_USER     = 4'b1010
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     enable,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [IR_WIDTH-1:0]      ir_value,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_update
);

    typedef enum logic [3:0] {
        TLR      = 4'h0,
        RTI      = 4'h1,
        SEL_DR   = 4'h2,
        CAP_DR   = 4'h3,
        SH_DR    = 4'h4,
        EX1_DR   = 4'h5,
        PAUSE_DR = 4'h6,
        EX2_DR   = 4'h7,
        UPD_DR   = 4'h8,
        SEL_IR   = 4'h9,
        CAP_IR   = 4'hA,
        SH_IR    = 4'hB,
        EX1_IR   = 4'hC,
        PAUSE_IR = 4'hD,
        EX2_IR   = 4'hE,
        UPD_IR   = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    // Capture pattern lets a board scan locate each IR in the chain.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    tap_state_t               state;
    tap_state_t               state_nxt;
    dr_sel_t                  dr_sel;
    logic [IR_WIDTH-1:0]      ir_shift;
    logic [31:0]              idcode_shift;
    logic [USER_DR_WIDTH-1:0] user_shift;
    logic [USER_DR_WIDTH:0]   user_shift_cat;
    logic                     bypass_reg;

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state <= TLR;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = TLR;
        case (state)
            TLR:      state_nxt = tms ? TLR    : RTI;
            RTI:      state_nxt = tms ? SEL_DR : RTI;
            SEL_DR:   state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:    state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_nxt = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nxt = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_nxt = tms ? SEL_DR : RTI;
            SEL_IR:   state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR:   state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:    state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_nxt = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nxt = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_nxt = tms ? SEL_IR : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_value)
            INST_IDCODE: dr_sel = DR_IDCODE;
            INST_USER:   dr_sel = DR_USER;
            INST_BYPASS: dr_sel = DR_BYPASS;
            default:     dr_sel = DR_BYPASS;
        endcase
    end

    assign user_shift_cat = {tdi, user_shift};

    // Instruction register: capture, shift, update, and reload on entry to TLR.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_shift <= '0;
            ir_value <= INST_IDCODE;
        end else if (enable) begin
            case (state)
                CAP_IR:  ir_shift <= IR_CAPTURE;
                SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPD_IR:  ir_value <= ir_shift;
                default: ;
            endcase
            if (state_nxt == TLR) begin
                ir_value <= INST_IDCODE;
            end
        end
    end

    // Data registers: only the register selected by ir_value moves.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
        end else if (enable) begin
            if (state == CAP_DR) begin
                case (dr_sel)
                    DR_IDCODE: idcode_shift <= IDCODE_VALUE;
                    DR_USER:   user_shift   <= user_dr_in;
                    default:   bypass_reg   <= 1'b0;
                endcase
            end else if (state == SH_DR) begin
                case (dr_sel)
                    DR_IDCODE: idcode_shift <= {tdi, idcode_shift[31:1]};
                    DR_USER:   user_shift   <= user_shift_cat[USER_DR_WIDTH:1];
                    default:   bypass_reg   <= tdi;
                endcase
            end
        end
    end

    // user_update is a registered pulse so it lands in the cycle after UpdDR.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            user_dr_out <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (enable && state == UPD_DR && dr_sel == DR_USER) begin
                user_dr_out <= user_shift;
                user_update <= 1'b1;
            end
        end
    end

    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        case (state)
            SH_IR: begin
                tdo    = ir_shift[0];
                tdo_en = 1'b1;
            end
            SH_DR: begin
                tdo_en = 1'b1;
                case (dr_sel)
                    DR_IDCODE: tdo = idcode_shift[0];
                    DR_USER:   tdo = user_shift[0];
                    default:   tdo = bypass_reg;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: expected tdo bits and user updates go into queues,
// a negedge monitor pops them whenever the TAP shifts or pulses user_update.
module tb_jtag_tap;

    localparam logic [31:0] IDC   = 32'h000FAF01;
    localparam logic [3:0]  OP_ID = 4'b1110;
    localparam logic [3:0]  OP_BY = 4'b1111;
    localparam logic [3:0]  OP_US = 4'b1010;

    logic       tck;
    logic       trst_n;
    logic       enable;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_value;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_update;

    logic       tdo_q[$];
    logic [7:0] upd_q[$];
    int         checks;
    int         errors;
    int         en_beats;
    int         upd_pulses;

    int         plen[16];
    logic [5:0] pbits[16];
    logic       psh[16];
    logic       pexp[16];

    jtag_tap dut (
        .tck         (tck),
        .trst_n      (trst_n),
        .enable      (enable),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .ir_value    (ir_value),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // Monitor: one tdo beat per enabled ShIR/ShDR cycle, one pop per user_update pulse.
    always @(negedge tck) begin
        logic       e;
        logic [7:0] u;
        if (trst_n && enable && tdo_en) begin
            en_beats++;
            if (tdo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tdo_unexpected actual=%b required=no_shift", tdo);
            end else begin
                e = tdo_q.pop_front();
                check("tdo", 32'(tdo), 32'(e));
            end
        end
        if (user_update) begin
            upd_pulses++;
            if (upd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL user_update_unexpected actual=1 required=0");
            end else begin
                u = upd_q.pop_front();
                check("user_dr_out_at_update", 32'(user_dr_out), 32'(u));
            end
        end
    end

    // From RTI: scan n bits of a DR, then Ex1DR -> UpdDR -> RTI.
    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] dexp);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tdo_q.push_back(dexp[i]);
            step(i == n - 1, din[i]);
        end
        check("dr_exit_tdo_en", 32'(tdo_en), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: load an opcode, expecting the 0001 capture pattern on tdo.
    task automatic load_ir(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tdo_q.push_back(i == 0);
            step(i == 3, op[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("ir_value_loaded", 32'(ir_value), 32'(op));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int p0;
        checks = 0; errors = 0; en_beats = 0; upd_pulses = 0;
        plen = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
        pbits = '{6'b000111, 6'b000000, 6'b000001, 6'b000001, 6'b000001, 6'b000101,
                  6'b000101, 6'b010101, 6'b001101, 6'b000011, 6'b000011, 6'b000011,
                  6'b001011, 6'b001011, 6'b101011, 6'b011011};
        psh  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        pexp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

        trst_n = 1'b0; enable = 1'b1; tms = 1'b0; tdi = 1'b0; user_dr_in = 8'h00;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_ir_value", 32'(ir_value), 32'(OP_ID));
        check("rst_user_dr_out", 32'(user_dr_out), 32'd0);
        check("rst_user_update", 32'(user_update), 32'd0);
        trst_n = 1'b1;
        step(1'b0, 1'b0);

        b0 = en_beats;
        dr_scan(32, 32'd0, IDC);
        check("idcode_en_beats", 32'(en_beats - b0), 32'd32);

        load_ir(OP_BY);
        dr_scan(5, 32'b01101, 32'b11010);
        check("bypass_no_update", 32'(upd_pulses), 32'd0);

        load_ir(OP_US);
        user_dr_in = 8'h3C;
        upd_q.push_back(8'hA5);
        p0 = upd_pulses;
        dr_scan(8, 32'hA5, 32'h3C);
        step(1'b0, 1'b0);
        check("user_update_low", 32'(user_update), 32'd0);
        check("user_dr_out", 32'(user_dr_out), 32'hA5);
        check("user_update_pulses", 32'(upd_pulses - p0), 32'd1);

        load_ir(OP_ID);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tdo_q.push_back(IDC[i]);
            step(1'b0, 1'b0);
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(k % 2 == 0, k % 2 == 1);
            check("hold_tdo", 32'(tdo), 32'(IDC[8]));
            check("hold_tdo_en", 32'(tdo_en), 32'd1);
        end
        enable = 1'b1;
        tdo_q.push_back(IDC[8]);
        step(1'b0, 1'b1);
        tdo_q.push_back(IDC[9]);
        step(1'b0, 1'b0);
        check("resume_tdo_en", 32'(tdo_en), 32'd1);
        trst_n = 1'b0;
        step(1'b0, 1'b0);
        trst_n = 1'b1;
        check("abort_tdo_en", 32'(tdo_en), 32'd0);
        check("abort_ir_value", 32'(ir_value), 32'(OP_ID));
        check("abort_user_dr_out", 32'(user_dr_out), 32'd0);
        step(1'b0, 1'b0);

        for (int s = 0; s < 16; s++) begin
            load_ir(OP_BY);
            for (int j = 0; j < plen[s]; j++) begin
                step(pbits[s][j], 1'b0);
            end
            if (psh[s]) begin
                tdo_q.push_back(pexp[s]);
            end
            for (int j = 0; j < 5; j++) begin
                step(1'b1, 1'b0);
            end
            check($sformatf("tlr_from_%0d_ir", s), 32'(ir_value), 32'(OP_ID));
            check($sformatf("tlr_from_%0d_en", s), 32'(tdo_en), 32'd0);
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            check($sformatf("tlr_from_%0d_shdr", s), 32'(tdo_en), 32'd1);
            tdo_q.push_back(1'b1);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end

        check("tdo_queue_drained", 32'(tdo_q.size()), 32'd0);
        check("upd_queue_drained", 32'(upd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
